// File: rtl/polar_pkg.sv
// Q16.16 polar-domain types and constants shared by the CORDIC stage and
// the frame statistic blocks downstream of it.
package polar_pkg;

    localparam int FRAC_W = 16;
    localparam logic signed [31:0] ANG_180 = 32'sd11796480;
    localparam logic signed [31:0] ANG_90  = 32'sd5898240;

    typedef struct packed {
        logic [31:0] amp;
        logic [31:0] ang;
    } polar_sample_t;

endpackage

// File: rtl/polar_result_slot.sv
// One-deep valid/ready result register. A load into a full slot that is not
// being drained in the same cycle is dropped and raises the sticky ovf flag.
module polar_result_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ovf
);

    logic accept;

    assign accept = load && (!valid || ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            // clr wins over a simultaneous drop
            if (clr)
                ovf <= 1'b0;
            else if (load && !accept)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/polar_peak_tracker.sv
// Per-frame peak amplitude/angle/index and above-threshold count over the
// CORDIC result stream, delivered through a one-deep valid/ready slot.
module polar_peak_tracker
    import polar_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             in_valid,
    input  logic [31:0]      in_amp,
    input  logic [31:0]      in_ang,
    input  logic [31:0]      thr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_amp,
    output logic [31:0]      res_ang,
    output logic [IDX_W-1:0] res_idx,
    output logic [IDX_W:0]   res_cnt,
    output logic             ovf
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam int PAY_W = 64 + 2 * IDX_W + 1;

    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] max_idx;
    logic [IDX_W:0]   above_cnt;
    polar_sample_t    max_s;

    logic             first;
    logic             above;
    logic             take;
    logic             accept;
    logic             done;
    polar_sample_t    nxt_s;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W:0]   nxt_above;
    logic [PAY_W-1:0] pay;
    logic [PAY_W-1:0] res_data;

    // The frame's running statistics including the current sample; these are
    // both the next accumulator state and the result payload at frame end.
    always_comb begin
        first     = (cnt == '0);
        above     = $signed(in_amp) > $signed(thr);
        take      = first || ($signed(in_amp) > $signed(max_s.amp));
        nxt_s     = max_s;
        nxt_idx   = max_idx;
        if (take) begin
            nxt_s.amp = in_amp;
            nxt_s.ang = in_ang;
            nxt_idx   = cnt;
        end
        nxt_above = (first ? '0 : above_cnt) + (IDX_W + 1)'(above);
    end

    assign accept = in_valid && !sync_clr;
    assign done   = accept && (cnt == LAST_IDX);
    assign pay    = {nxt_s.amp, nxt_s.ang, nxt_idx, nxt_above};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            max_idx   <= '0;
            above_cnt <= '0;
            max_s     <= '0;
        end else if (sync_clr) begin
            cnt       <= '0;
            above_cnt <= '0;
        end else if (in_valid) begin
            cnt       <= done ? '0 : cnt + 1'b1;
            max_s     <= nxt_s;
            max_idx   <= nxt_idx;
            above_cnt <= nxt_above;
        end
    end

    polar_result_slot #(.W(PAY_W)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (sync_clr),
        .load      (done),
        .load_data (pay),
        .ready     (res_ready),
        .valid     (res_valid),
        .data      (res_data),
        .ovf       (ovf)
    );

    assign {res_amp, res_ang, res_idx, res_cnt} = res_data;

endmodule

// File: tb/tb_polar_peak_tracker.sv
// Directed and randomized check of polar_peak_tracker (FRAME_LEN=4) against
// a frame-level reference model built from sample lists.
module tb_polar_peak_tracker;

    localparam int FL    = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sync_clr;
    logic             in_valid;
    logic [31:0]      in_amp;
    logic [31:0]      in_ang;
    logic [31:0]      thr;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_amp;
    logic [31:0]      res_ang;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W:0]   res_cnt;
    logic             ovf;

    polar_peak_tracker #(.FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .in_amp    (in_amp),
        .in_ang    (in_ang),
        .thr       (thr),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_amp   (res_amp),
        .res_ang   (res_ang),
        .res_idx   (res_idx),
        .res_cnt   (res_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: samples of the running frame and the expected outputs
    logic signed [31:0] f_amp[$];
    logic signed [31:0] f_ang[$];
    int                 f_above[$];
    logic        e_valid;
    logic [31:0] e_amp;
    logic [31:0] e_ang;
    int          e_idx;
    int          e_cnt;
    logic        e_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_valid"}, 64'(res_valid), 64'(e_valid));
        chk({tag, "_ovf"},   64'(ovf),       64'(e_ovf));
        chk({tag, "_amp"},   64'(res_amp),   64'(e_amp));
        chk({tag, "_ang"},   64'(res_ang),   64'(e_ang));
        chk({tag, "_idx"},   64'(res_idx),   64'(e_idx));
        chk({tag, "_cnt"},   64'(res_cnt),   64'(e_cnt));
    endtask

    task automatic model_reset();
        f_amp.delete(); f_ang.delete(); f_above.delete();
        e_valid = 0; e_amp = 0; e_ang = 0; e_idx = 0; e_cnt = 0; e_ovf = 0;
    endtask

    // one clock cycle of stimulus; model is updated from the rules, then checked
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] g,
                        input logic rdy, input logic clr);
        bit   complete = 0;
        int   best = 0;
        int   above = 0;
        in_valid = v; in_amp = a; in_ang = g; res_ready = rdy; sync_clr = clr;
        if (clr) begin
            f_amp.delete(); f_ang.delete(); f_above.delete();
        end else if (v) begin
            f_amp.push_back($signed(a));
            f_ang.push_back($signed(g));
            f_above.push_back(($signed(a) > $signed(thr)) ? 1 : 0);
            if (f_amp.size() == FL) begin
                complete = 1;
                for (int i = 1; i < FL; i++)
                    if (f_amp[i] > f_amp[best]) best = i;
                for (int i = 0; i < FL; i++) above += f_above[i];
            end
        end
        if (complete && (!e_valid || rdy)) begin
            e_valid = 1; e_amp = f_amp[best]; e_ang = f_ang[best];
            e_idx = best; e_cnt = above;
        end else if (complete) begin
            e_ovf = 1;
        end else if (e_valid && rdy) begin
            e_valid = 0;
        end
        if (clr) e_ovf = 0;
        if (complete) begin
            f_amp.delete(); f_ang.delete(); f_above.delete();
        end
        @(posedge clk); #1;
        in_valid = 0; sync_clr = 0;
        chk_all("step");
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    function automatic logic [31:0] deg(input int d);
        return 32'(d * 65536);
    endfunction

    initial begin
        logic [31:0] amps[4];
        rst_n = 0; sync_clr = 0; in_valid = 0; in_amp = 0; in_ang = 0;
        thr = 0; res_ready = 0;
        model_reset();
        #3;
        chk_all("reset");
        @(negedge clk); rst_n = 1;

        // basic frame
        thr = 32'h0;
        amps = '{32'h10000, 32'h30000, 32'h20000, 32'h8000};
        for (int i = 0; i < 4; i++) step(1'b1, amps[i], deg(10 * (i + 1)), 1'b1, 1'b0);
        chk("basic_valid", 64'(res_valid), 64'd1);
        chk("basic_amp",   64'(res_amp),   64'h30000);
        chk("basic_ang",   64'(res_ang),   64'd1310720);
        chk("basic_idx",   64'(res_idx),   64'd1);
        chk("basic_cnt",   64'(res_cnt),   64'd4);
        idle(1'b1);
        chk("basic_pulse", 64'(res_valid), 64'd0);

        // ties keep earliest, threshold is strict
        thr = 32'h10000;
        amps = '{32'h20000, 32'h20000, 32'h10000, 32'h10000};
        for (int i = 0; i < 4; i++) step(1'b1, amps[i], deg(5 * i), 1'b1, 1'b0);
        chk("tie_idx", 64'(res_idx), 64'd0);
        chk("tie_cnt", 64'(res_cnt), 64'd2);
        idle(1'b1);

        // backpressure overflow
        thr = 32'h0;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 * (i + 1), deg(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h9000 - 32'h1000 * i, deg(50 + i), 1'b0, 1'b0);
        chk("bp_ovf", 64'(ovf), 64'd1);
        chk("bp_hold_amp", 64'(res_amp), 64'h4000);
        idle(1'b0);
        idle(1'b1);
        chk("bp_drained", 64'(res_valid), 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("bp_ovf_clr", 64'(ovf), 64'd0);

        // simultaneous accept and completion
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 * (i + 1), deg(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h5000 + 32'h100 * i, deg(90 + i), (i == 3), 1'b0);
        chk("sim_valid", 64'(res_valid), 64'd1);
        chk("sim_amp",   64'(res_amp),   64'h5300);
        chk("sim_ovf",   64'(ovf),       64'd0);
        idle(1'b1);

        // mid-frame abort
        step(1'b1, 32'h7f0000, deg(1), 1'b1, 1'b0);
        step(1'b1, 32'h7f0000, deg(2), 1'b1, 1'b0);
        step(1'b1, 32'h7f0000, deg(3), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h11000 * (i + 1), deg(-20 * i), 1'b1, 1'b0);
        chk("abort_amp", 64'(res_amp), 64'h44000);
        chk("abort_idx", 64'(res_idx), 64'd3);
        idle(1'b1);

        // reset mid-frame with a pending result
        for (int i = 0; i < 4; i++) step(1'b1, 32'h2000 + i, deg(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3000, deg(i), 1'b0, 1'b0);
        #2; rst_n = 0; #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk); rst_n = 1;
        amps = '{32'h100, 32'h200, 32'h900, 32'h300};
        for (int i = 0; i < 4; i++) step(1'b1, amps[i], deg(-i), 1'b1, 1'b0);
        chk("rst_idx", 64'(res_idx), 64'd2);
        idle(1'b1);

        // randomized traffic including negative amplitudes, ties and aborts
        for (int n = 0; n < 300; n++) begin
            thr = 32'((int'($urandom_range(0, 15)) - 4) * 32'h4000);
            step($urandom_range(0, 3) != 0,
                 32'((int'($urandom_range(0, 15)) - 4) * 32'h4000),
                 32'(int'($urandom_range(0, 360)) - 180) << 16,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
